// File: rtl/apb_defs.sv
// Shared APB definitions: FSM state encoding and default bus widths,
// common to the requester and the error-reporting slave.
package apb_defs;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage : apb_defs

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter for the APB ACCESS phase; flags expiry when
// the count reaches TIMEOUT-1. TIMEOUT = 0 disables expiry entirely.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                 CNT_W  = $clog2(TIMEOUT) + 1;
    localparam int                 LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0]   LAST   = LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    if (TIMEOUT == 0) begin : g_disabled
        assign expired = 1'b0;
    end else begin : g_enabled
        assign expired = (count == LAST);
    end

endmodule : apb_wait_timer

// File: rtl/apb_master_err.sv
// APB requester: turns single-beat local commands into SETUP/ACCESS transfers,
// with a local address-range check and a wait-state timeout.
module apb_master_err
    import apb_defs::*;
#(
    parameter int ADDR_W     = APB_ADDR_W,
    parameter int DATA_W     = APB_DATA_W,
    parameter int ADDR_LIMIT = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(ADDR_LIMIT);

    apb_state_e        state, state_next;
    logic              accept, in_range;
    logic              timer_expired;
    logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    // Holding off a new command while a response is on the bus keeps
    // back-to-back responses separated by at least one idle cycle.
    assign cmd_ready = (state == IDLE) && !rsp_valid;
    assign accept    = cmd_valid && cmd_ready;
    assign in_range  = (cmd_addr < LIMIT);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (state == SETUP),
        .enable  ((state == ACCESS) && !pready),
        .expired (timer_expired)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        state_next = SETUP;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                // pready is checked first so a completion in the expiry cycle wins.
                if (pready) begin
                    state_next  = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    if (!pwrite && !pslverr) begin
                        rsp_rdata_d = prdata;
                    end
                end else if (timer_expired) begin
                    state_next    = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_next;
            psel        <= (state_next != IDLE);
            penable     <= (state_next == ACCESS);
            if (accept && in_range) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end
            rsp_valid   <= rsp_valid_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            rsp_rdata   <= rsp_rdata_d;
        end
    end

endmodule : apb_master_err

// File: tb/tb_apb_master_err.sv
// Scoreboard bench for apb_master_err with a small behavioural APB slave
// whose wait states and error response are set per test.
module tb_apb_master_err;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic       to;
    } exp_t;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [7:0]  rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr;
    logic [7:0]  pwdata, prdata;
    logic        pready, pslverr;

    int   checks = 0;
    int   errors = 0;
    int   rsp_count = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    int         wait_cycles = 0;
    int         wait_cnt = 0;
    logic       slv_err = 1'b0;
    logic [7:0] mem [16];

    always #5 pclk = ~pclk;

    apb_master_err dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    // Behavioural slave: ready after wait_cycles ACCESS cycles.
    assign pready  = psel && penable && (wait_cnt >= wait_cycles);
    assign pslverr = slv_err;
    assign prdata  = slv_err ? 8'h3C : ((paddr < 32'd16) ? mem[paddr[3:0]] : 8'h00);

    always @(posedge pclk) begin
        if (psel && penable && !pready) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
        if (psel && penable && pready && pwrite && !slv_err && (paddr < 32'd16))
            mem[paddr[3:0]] <= pwdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response appears.
    always @(negedge pclk) begin
        if (presetn && rsp_valid) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata",   {24'b0, rsp_rdata},   {24'b0, mon_e.rdata});
                check("rsp_err",     {31'b0, rsp_err},     {31'b0, mon_e.err});
                check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, mon_e.to});
            end
        end
    end

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [7:0] d,
                           input exp_t e, output int lat, output int acc,
                           output int psel_at, output int pen_at, output logic psel_end);
        int guard;
        exp_q.push_back(e);
        @(posedge pclk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(posedge pclk); #1;
            guard++;
        end
        check("ready_wait", {31'b0, cmd_ready}, 32'd1);
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        lat = 0; acc = 0; psel_at = -1; pen_at = -1; psel_end = 1'b0;
        while (lat < 64) begin
            @(negedge pclk);
            lat++;
            if (psel && psel_at < 0)    psel_at = lat;
            if (penable && pen_at < 0)  pen_at = lat;
            if (psel && penable)        acc++;
            if (rsp_valid) begin
                psel_end = psel;
                break;
            end
        end
        if (!rsp_valid) check("rsp_wait", {31'b0, rsp_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat, acc, psel_at, pen_at, rc;
        logic psel_end;

        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0;
        @(negedge pclk);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_psel",      {31'b0, psel},      32'd0);
        check("rst_penable",   {31'b0, penable},   32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_paddr",     paddr,              32'd0);
        @(negedge pclk);
        presetn = 1'b1;

        // Zero-wait write: psel T+1, penable T+2, response T+3.
        wait_cycles = 0;
        run_cmd(1'b1, 32'h5, 8'hA5, '{8'h00, 1'b0, 1'b0}, lat, acc, psel_at, pen_at, psel_end);
        check("wr_psel_at",  psel_at, 32'd1);
        check("wr_pen_at",   pen_at,  32'd2);
        check("wr_rsp_lat",  lat,     32'd3);
        check("wr_psel_end", {31'b0, psel_end}, 32'd0);
        check("wr_no_ready_on_rsp", {31'b0, cmd_ready}, 32'd0);
        check("wr_paddr_hold", paddr, 32'h5);
        check("wr_pwdata_hold", {24'b0, pwdata}, 32'hA5);

        run_cmd(1'b0, 32'h5, 8'h00, '{8'hA5, 1'b0, 1'b0}, lat, acc, psel_at, pen_at, psel_end);
        check("rd_rsp_lat", lat, 32'd3);

        // Local decode errors: 20 and the first rejected address 16.
        run_cmd(1'b1, 32'd20, 8'h11, '{8'h00, 1'b1, 1'b0}, lat, acc, psel_at, pen_at, psel_end);
        check("dec20_lat",  lat,     32'd1);
        check("dec20_psel", psel_at, 32'hFFFF_FFFF);
        run_cmd(1'b0, 32'd16, 8'h00, '{8'h00, 1'b1, 1'b0}, lat, acc, psel_at, pen_at, psel_end);
        check("dec16_psel", psel_at, 32'hFFFF_FFFF);

        // Highest legal address 15.
        run_cmd(1'b1, 32'd15, 8'h5A, '{8'h00, 1'b0, 1'b0}, lat, acc, psel_at, pen_at, psel_end);
        check("a15_wr_psel", psel_at, 32'd1);
        run_cmd(1'b0, 32'd15, 8'h00, '{8'h5A, 1'b0, 1'b0}, lat, acc, psel_at, pen_at, psel_end);

        // Three wait states.
        wait_cycles = 3;
        run_cmd(1'b1, 32'h2, 8'h77, '{8'h00, 1'b0, 1'b0}, lat, acc, psel_at, pen_at, psel_end);
        check("ws3_access", acc, 32'd4);
        check("ws3_lat",    lat, 32'd6);
        run_cmd(1'b0, 32'h2, 8'h00, '{8'h77, 1'b0, 1'b0}, lat, acc, psel_at, pen_at, psel_end);

        // Stuck slave: abort after 16 ACCESS cycles.
        wait_cycles = 1000;
        run_cmd(1'b0, 32'h3, 8'h00, '{8'h00, 1'b1, 1'b1}, lat, acc, psel_at, pen_at, psel_end);
        check("to_access",   acc, 32'd16);
        check("to_lat",      lat, 32'd18);
        check("to_psel_end", {31'b0, psel_end}, 32'd0);

        // pready arrives in the expiry cycle: normal completion.
        wait_cycles = 15;
        run_cmd(1'b0, 32'h5, 8'h00, '{8'hA5, 1'b0, 1'b0}, lat, acc, psel_at, pen_at, psel_end);
        check("edge_access", acc, 32'd16);

        // Slave errors on read and write.
        wait_cycles = 0;
        slv_err = 1'b1;
        run_cmd(1'b0, 32'h5, 8'h00, '{8'h00, 1'b1, 1'b0}, lat, acc, psel_at, pen_at, psel_end);
        run_cmd(1'b1, 32'h5, 8'hFF, '{8'h00, 1'b1, 1'b0}, lat, acc, psel_at, pen_at, psel_end);
        slv_err = 1'b0;

        // Reset during ACCESS: outputs drop at once, no response for the lost command.
        wait_cycles = 1000;
        @(posedge pclk); #1;
        check("prerst_ready", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        check("prerst_penable", {31'b0, penable}, 32'd1);
        rc = rsp_count;
        #2 presetn = 1'b0;
        #1;
        check("rst_async_psel",    {31'b0, psel},      32'd0);
        check("rst_async_penable", {31'b0, penable},   32'd0);
        check("rst_async_rsp",     {31'b0, rsp_valid}, 32'd0);
        @(negedge pclk);
        @(negedge pclk);
        wait_cycles = 0;
        presetn = 1'b1;
        repeat (4) @(negedge pclk);
        check("postrst_ready",   {31'b0, cmd_ready}, 32'd1);
        check("postrst_no_rsp",  rsp_count,          rc);
        check("postrst_psel",    {31'b0, psel},      32'd0);

        run_cmd(1'b0, 32'h5, 8'h00, '{8'hA5, 1'b0, 1'b0}, lat, acc, psel_at, pen_at, psel_end);
        check("postrst_rd_lat", lat, 32'd3);

        repeat (3) @(negedge pclk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_master_err
